// File: rtl/nor_logic_unit_bist_if.sv
// Operand/result valid-ready bundle for the NOR logic unit.
// master drives operands and consumes results; slave is the unit.
interface nor_logic_unit_bist_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, y
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, y
    );
endinterface

// File: rtl/nor_logic_unit_bist.sv
// NOR-only bitwise logic unit with a registered valid/ready output
// stage and an exhaustive self-test sequencer.
module nor_logic_unit_bist #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    nor_logic_unit_bist_if.slave bus,
    input  logic                 bist_start,
    input  logic                 bist_inject,
    output logic                 bist_busy,
    output logic                 bist_done,
    output logic                 bist_pass,
    output logic [7:0]           bist_err_count
);
    localparam int CW = 3 + 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [CW-1:0]    cnt;
    logic             cmp_fail;
    logic [2:0]       dp_op;
    logic [WIDTH-1:0] dp_a;
    logic [WIDTH-1:0] dp_b;
    logic [WIDTH-1:0] dp_raw;
    logic [WIDTH-1:0] dp_res;
    logic [WIDTH-1:0] ref_res;
    logic             run;
    logic             drain;
    logic             start_ok;
    logic             xfer;
    logic             err_inc;
    logic [7:0]       err_nxt;

    // The only primitive: a bitwise 2-input NOR, written without
    // logic operators so every op below is a pure NOR network.
    function automatic logic [WIDTH-1:0] nor2(
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] z
    );
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = (x[i] || z[i]) ? 1'b0 : 1'b1;
        end
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] nor_eval(
        input logic [2:0]       f,
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] z
    );
        logic [WIDTH-1:0] nx, nz, n1, n2, n3;
        logic [WIDTH-1:0] orv, andv, nandv;
        logic [WIDTH-1:0] xnorv, xorv, pass;
        logic [WIDTH-1:0] r;
        nx    = nor2(x, x);
        nz    = nor2(z, z);
        n1    = nor2(x, z);
        orv   = nor2(n1, n1);
        andv  = nor2(nx, nz);
        nandv = nor2(andv, andv);
        n2    = nor2(x, n1);
        n3    = nor2(z, n1);
        xnorv = nor2(n2, n3);
        xorv  = nor2(xnorv, xnorv);
        pass  = nor2(nx, nx);
        r     = '0;
        unique case (1'b1)
            f == 3'd0: r = andv;
            f == 3'd1: r = orv;
            f == 3'd2: r = nx;
            f == 3'd3: r = xorv;
            f == 3'd4: r = xnorv;
            f == 3'd5: r = n1;
            f == 3'd6: r = nandv;
            f == 3'd7: r = pass;
            default:   r = '0;
        endcase
        return r;
    endfunction

    // Plain operator reference the self-test compares against.
    function automatic logic [WIDTH-1:0] ref_eval(
        input logic [2:0]       f,
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] z
    );
        logic [WIDTH-1:0] r;
        case (f)
            3'd0:    r = x & z;
            3'd1:    r = x | z;
            3'd2:    r = ~x;
            3'd3:    r = x ^ z;
            3'd4:    r = ~(x ^ z);
            3'd5:    r = ~(x | z);
            3'd6:    r = ~(x & z);
            default: r = x;
        endcase
        return r;
    endfunction

    assign run   = (state == RUN);
    assign drain = (state == DRAIN);

    assign start_ok = (state == IDLE) && bist_start && !bus.out_valid;
    assign bus.in_ready = (state == IDLE) && !bist_start &&
                          (!bus.out_valid || bus.out_ready);
    assign xfer = bus.in_valid && bus.in_ready;

    assign bist_busy = run || drain;
    assign bist_done = (state == DONE);

    // Datapath input mux: self-test vector in RUN, operands otherwise.
    always_comb begin
        dp_op = bus.op;
        dp_a  = bus.a;
        dp_b  = bus.b;
        if (run) begin
            dp_op = cnt[CW-1 -: 3];
            dp_a  = cnt[2*WIDTH-1 -: WIDTH];
            dp_b  = cnt[WIDTH-1:0];
        end
    end

    // NOR datapath, reference and optional bit-0 fault during RUN.
    always_comb begin
        dp_raw  = nor_eval(dp_op, dp_a, dp_b);
        ref_res = ref_eval(dp_op, dp_a, dp_b);
        dp_res  = dp_raw;
        if (run && bist_inject) begin
            dp_res[0] = dp_raw[0] ? 1'b0 : 1'b1;
        end
    end

    // Saturating error count including the compare being retired.
    always_comb begin
        err_inc = (run || drain) && cmp_fail &&
                  (bist_err_count != 8'hFF);
        err_nxt = bist_err_count + (err_inc ? 8'd1 : 8'd0);
    end

    // BIST state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // BIST next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start_ok) state_nxt = RUN;
            RUN:   if (&cnt)     state_nxt = DRAIN;
            DRAIN: state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Exhaustive vector counter over {op,a,b}.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        cnt <= '0;
        else if (start_ok) cnt <= '0;
        else if (run)      cnt <= cnt + 1'b1;
    end

    // Registered compare, error accumulation and pass verdict.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_fail       <= 1'b0;
            bist_err_count <= 8'd0;
            bist_pass      <= 1'b0;
        end else if (start_ok) begin
            cmp_fail       <= 1'b0;
            bist_err_count <= 8'd0;
            bist_pass      <= 1'b0;
        end else begin
            cmp_fail       <= run && (dp_res != ref_res);
            bist_err_count <= err_nxt;
            if (drain) bist_pass <= (err_nxt == 8'd0);
        end
    end

    // One-deep output register with same-cycle replace.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.y         <= '0;
            bus.out_valid <= 1'b0;
        end else if (xfer) begin
            bus.y         <= dp_res;
            bus.out_valid <= 1'b1;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_nor_logic_unit_bist.sv
// Self-checking bench: directed sweep, random handshake against a
// behavioural model, and clean/faulted/interrupted self-tests.
module tb_nor_logic_unit_bist;
    localparam int W = 4;
    localparam int N = 1 << (3 + 2 * W);

    logic       clk;
    logic       rst_n;
    logic       bist_start;
    logic       bist_inject;
    logic       bist_busy;
    logic       bist_done;
    logic       bist_pass;
    logic [7:0] bist_err_count;

    int n_chk;
    int n_err;

    nor_logic_unit_bist_if #(.WIDTH(W)) bus ();

    nor_logic_unit_bist #(.WIDTH(W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus),
        .bist_start     (bist_start),
        .bist_inject    (bist_inject),
        .bist_busy      (bist_busy),
        .bist_done      (bist_done),
        .bist_pass      (bist_pass),
        .bist_err_count (bist_err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] model_f(
        input int           f,
        input logic [W-1:0] x,
        input logic [W-1:0] z
    );
        case (f)
            0:       return x & z;
            1:       return x | z;
            2:       return ~x;
            3:       return x ^ z;
            4:       return ~(x ^ z);
            5:       return ~(x | z);
            6:       return ~(x & z);
            default: return x;
        endcase
    endfunction

    task automatic run_bist(
        input  bit         inj,
        output int         bcyc,
        output int         dcyc,
        output int         viol,
        output logic       pass_o,
        output logic [7:0] err_o
    );
        bcyc   = 0;
        dcyc   = 0;
        viol   = 0;
        pass_o = 1'b0;
        err_o  = 8'd0;
        @(posedge clk); #1;
        bist_start    = 1'b1;
        bist_inject   = inj;
        bus.in_valid  = 1'b1;
        bus.op        = 3'($urandom_range(7));
        bus.a         = W'($urandom);
        bus.b         = W'($urandom);
        bus.out_ready = 1'($urandom);
        @(negedge clk);
        if (bus.in_ready) viol++;
        @(posedge clk); #1;
        bist_start   = 1'b0;
        bus.in_valid = 1'b0;
        for (int c = 0; c < N + 50; c++) begin
            @(negedge clk);
            if (bist_busy) begin
                bcyc++;
                if (bus.in_ready || bus.out_valid) viol++;
            end
            if (bist_done) begin
                dcyc++;
                pass_o = bist_pass;
                err_o  = bist_err_count;
                if (bist_busy) viol++;
            end else if (dcyc > 0) begin
                break;
            end
        end
        bist_inject = 1'b0;
    endtask

    initial begin
        logic [W-1:0] tbl [8];
        logic [W-1:0] my;
        logic         mv;
        logic         exp_rdy;
        int           bc, dc, vi, exp_err;
        logic         ps;
        logic [7:0]   ec;
        bit           seen;

        n_chk = 0;
        n_err = 0;
        tbl[0] = 4'b1000; tbl[1] = 4'b1110;
        tbl[2] = 4'b0011; tbl[3] = 4'b0110;
        tbl[4] = 4'b1001; tbl[5] = 4'b0001;
        tbl[6] = 4'b0111; tbl[7] = 4'b1100;

        rst_n         = 1'b0;
        bist_start    = 1'b0;
        bist_inject   = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.op        = '0;
        bus.out_ready = 1'b0;
        #22;
        chk("rst_y", 32'(bus.y), 0);
        chk("rst_ov", 32'(bus.out_valid), 0);
        chk("rst_rdy", 32'(bus.in_ready), 1);
        chk("rst_busy", 32'(bist_busy), 0);
        chk("rst_done", 32'(bist_done), 0);
        chk("rst_pass", 32'(bist_pass), 0);
        chk("rst_err", 32'(bist_err_count), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed sweep, one op per cycle.
        @(posedge clk); #1;
        bus.a         = 4'b1100;
        bus.b         = 4'b1010;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.op        = 3'd0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            chk($sformatf("sweep_ov%0d", i),
                32'(bus.out_valid), 1);
            chk($sformatf("sweep_y%0d", i), 32'(bus.y),
                32'(tbl[i]));
            if (i < 7) bus.op = 3'(i + 1);
            else       bus.in_valid = 1'b0;
        end

        // Backpressure and same-cycle replace.
        @(posedge clk); #1;
        bus.in_valid  = 1'b1;
        bus.op        = 3'd5;
        bus.a         = 4'b0011;
        bus.b         = 4'b0000;
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("bp_rdy0", 32'(bus.in_ready), 1);
        @(posedge clk); #1;
        chk("bp_y1", 32'(bus.y), 32'(4'b1100));
        bus.op = 3'd0;
        bus.a  = 4'b1111;
        bus.b  = 4'b0101;
        repeat (3) begin
            @(negedge clk);
            chk("bp_block", 32'(bus.in_ready), 0);
            chk("bp_hold", 32'(bus.y), 32'(4'b1100));
            chk("bp_ov", 32'(bus.out_valid), 1);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_rdy1", 32'(bus.in_ready), 1);
        @(posedge clk); #1;
        chk("bp_repl_ov", 32'(bus.out_valid), 1);
        chk("bp_y2", 32'(bus.y), 32'(4'b0101));
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;

        // Start ignored while the output register is full.
        bist_start = 1'b1;
        @(negedge clk);
        chk("blk_rdy", 32'(bus.in_ready), 0);
        @(posedge clk); #1;
        bist_start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("blk_busy", 32'(bist_busy), 0);
            chk("blk_y", 32'(bus.y), 32'(4'b0101));
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("blk_drain", 32'(bus.out_valid), 0);

        // Random handshake traffic against the model.
        mv = 1'b0;
        my = '0;
        for (int t = 0; t < 60; t++) begin
            @(posedge clk); #1;
            bus.in_valid  = 1'($urandom);
            bus.out_ready = 1'($urandom);
            bus.op        = 3'($urandom_range(7));
            bus.a         = W'($urandom);
            bus.b         = W'($urandom);
            @(negedge clk);
            exp_rdy = !mv || bus.out_ready;
            chk("rnd_rdy", 32'(bus.in_ready), 32'(exp_rdy));
            chk("rnd_ov", 32'(bus.out_valid), 32'(mv));
            if (mv) chk("rnd_y", 32'(bus.y), 32'(my));
            if (bus.in_valid && exp_rdy) begin
                my = model_f(int'(bus.op), bus.a, bus.b);
                mv = 1'b1;
            end else if (bus.out_ready) begin
                mv = 1'b0;
            end
        end
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("rnd_drain", 32'(bus.out_valid), 0);

        // Faulted self-test: every vector miscompares.
        exp_err = (N > 255) ? 255 : N;
        run_bist(1'b1, bc, dc, vi, ps, ec);
        chk("flt_busy", 32'(bc), 32'(N + 1));
        chk("flt_done", 32'(dc), 1);
        chk("flt_viol", 32'(vi), 0);
        chk("flt_pass", 32'(ps), 0);
        chk("flt_err", 32'(ec), 32'(exp_err));

        // Clean self-test with an operand offered at start.
        run_bist(1'b0, bc, dc, vi, ps, ec);
        chk("cln_busy", 32'(bc), 32'(N + 1));
        chk("cln_done", 32'(dc), 1);
        chk("cln_viol", 32'(vi), 0);
        chk("cln_pass", 32'(ps), 1);
        chk("cln_err", 32'(ec), 0);
        chk("cln_ov", 32'(bus.out_valid), 0);

        // Reset in the middle of a faulted run.
        @(posedge clk); #1;
        bist_start  = 1'b1;
        bist_inject = 1'b1;
        @(posedge clk); #1;
        bist_start = 1'b0;
        repeat (99) @(posedge clk);
        #3;
        chk("mid_busy", 32'(bist_busy), 1);
        chk("mid_errnz", 32'(bist_err_count != 0), 1);
        rst_n = 1'b0;
        #1;
        chk("mr_busy", 32'(bist_busy), 0);
        chk("mr_done", 32'(bist_done), 0);
        chk("mr_pass", 32'(bist_pass), 0);
        chk("mr_err", 32'(bist_err_count), 0);
        chk("mr_ov", 32'(bus.out_valid), 0);
        chk("mr_y", 32'(bus.y), 0);
        chk("mr_rdy", 32'(bus.in_ready), 1);
        bist_inject = 1'b0;
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (bist_done || bist_busy) seen = 1'b1;
        end
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (bist_done || bist_busy) seen = 1'b1;
        end
        chk("mr_quiet", 32'(seen), 0);
        run_bist(1'b0, bc, dc, vi, ps, ec);
        chk("re_busy", 32'(bc), 32'(N + 1));
        chk("re_done", 32'(dc), 1);
        chk("re_pass", 32'(ps), 1);
        chk("re_err", 32'(ec), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
